// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with memory-wait FSM and perf counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       i_id_rs1,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_use_rs1,
    input  logic             i_id_use_rs2,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_ex_br_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_bubble,
    output logic             o_exmem_en,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t           r_state, w_state_nxt;
    logic [WW-1:0]    r_wait_cnt, w_wait_nxt;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_lu, w_frz;

    assign w_lu = i_ex_memread && (i_ex_rd != 5'd0) &&
                  ((i_id_use_rs1 && i_id_rs1 == i_ex_rd) || (i_id_use_rs2 && i_id_rs2 == i_ex_rd));
    assign w_frz = (r_state == RUN && i_mem_req && !i_mem_ready) ||
                   (r_state == WAIT && !i_mem_ready) || r_state == ERR;

    assign o_mem_err   = (r_state == ERR);
    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

    // next state / wait counter: wait_cnt counts frozen not-ready cycles before giving up
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        case (r_state)
            RUN: if (i_mem_req && !i_mem_ready) begin
                w_state_nxt = WAIT;
                w_wait_nxt  = WW'(1);
            end
            WAIT: if (i_mem_ready) begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end else if (r_wait_cnt == WW'(MEM_TIMEOUT)) begin
                w_state_nxt = ERR;
            end else begin
                w_wait_nxt  = r_wait_cnt + WW'(1);
            end
            ERR: w_state_nxt = ERR;
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // pipeline controls: reset forces a bubble, then freeze > branch squash > load-use > normal
    always_comb begin
        {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_exmem_en} = 5'b11001;
        if (reset)
            {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_exmem_en} = 5'b00110;
        else if (w_frz)
            {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_exmem_en} = 5'b00000;
        else if (i_ex_br_taken)
            {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_exmem_en} = 5'b11111;
        else if (w_lu)
            {o_pc_en, o_ifid_en, o_ifid_flush, o_idex_bubble, o_exmem_en} = 5'b00011;
    end

    // state register and wait counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // saturating stall/flush performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!o_pc_en && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (o_ifid_flush && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of hazard priorities, memory wait/timeout, reset and counter saturation
module tb_pipeline_hazard_ctrl;
    logic       clk, reset;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       use1, use2, memread, br, req, rdy;
    logic       pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, mem_err;
    logic [3:0] stall_cnt, flush_cnt;
    logic [4:0] ctl;
    int         checks = 0;
    int         errors = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2), .i_id_use_rs1(use1), .i_id_use_rs2(use2),
        .i_ex_memread(memread), .i_ex_rd(ex_rd), .i_ex_br_taken(br),
        .i_mem_req(req), .i_mem_ready(rdy),
        .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_ifid_flush(ifid_flush),
        .o_idex_bubble(idex_bubble), .o_exmem_en(exmem_en), .o_mem_err(mem_err),
        .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
    );

    assign ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en};

    // clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr;
        {id_rs1, id_rs2, ex_rd} = '0;
        {use1, use2, memread, br, req, rdy} = '0;
    endtask

    // directed stimulus; ctl = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en}
    initial begin
        reset = 1'b1;
        clr();
        #3;
        chk("rst_ctl", 32'(ctl), 32'b00110);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_flush", 32'(flush_cnt), 0);
        chk("rst_err", 32'(mem_err), 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("normal_ctl", 32'(ctl), 32'b11001);
        tick();
        chk("normal_stall", 32'(stall_cnt), 0);
        memread = 1; ex_rd = 5; id_rs1 = 5; use1 = 1;
        #1 chk("lu_rs1_ctl", 32'(ctl), 32'b00011);
        tick();
        chk("lu_rs1_stall", 32'(stall_cnt), 1);
        clr();
        #1 chk("after_lu_ctl", 32'(ctl), 32'b11001);
        tick();
        chk("after_lu_stall", 32'(stall_cnt), 1);
        memread = 1; ex_rd = 9; id_rs2 = 9; use2 = 1; id_rs1 = 3; use1 = 1;
        #1 chk("lu_rs2_ctl", 32'(ctl), 32'b00011);
        tick();
        chk("lu_rs2_stall", 32'(stall_cnt), 2);
        clr();
        memread = 1; ex_rd = 0; id_rs1 = 0; use1 = 1;
        #1 chk("x0_ctl", 32'(ctl), 32'b11001);
        tick();
        clr();
        memread = 1; ex_rd = 7; id_rs2 = 7; use2 = 0;
        #1 chk("nouse_ctl", 32'(ctl), 32'b11001);
        tick();
        chk("nouse_stall", 32'(stall_cnt), 2);
        clr();
        br = 1; memread = 1; ex_rd = 5; id_rs1 = 5; use1 = 1;
        #1 chk("br_lu_ctl", 32'(ctl), 32'b11111);
        tick();
        chk("br_flush", 32'(flush_cnt), 1);
        chk("br_stall", 32'(stall_cnt), 2);
        clr();
        req = 1; rdy = 0;
        #1 chk("wait1_ctl", 32'(ctl), 32'b00000);
        tick();
        br = 1;
        #1 chk("wait2_frz_over_br", 32'(ctl), 32'b00000);
        tick();
        br = 0;
        #1 chk("wait3_ctl", 32'(ctl), 32'b00000);
        tick();
        rdy = 1;
        #1 chk("release_ctl", 32'(ctl), 32'b11001);
        tick();
        chk("wait_stall", 32'(stall_cnt), 5);
        chk("wait_flush", 32'(flush_cnt), 1);
        #1 chk("run_req_ready_ctl", 32'(ctl), 32'b11001);
        tick();
        chk("run_req_ready_stall", 32'(stall_cnt), 5);
        clr();
        req = 1; rdy = 0;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("to_frz%0d_ctl", i), 32'(ctl), 32'b00000);
            chk($sformatf("to_frz%0d_err", i), 32'(mem_err), 0);
            tick();
        end
        chk("to_err_set", 32'(mem_err), 1);
        chk("to_stall", 32'(stall_cnt), 10);
        req = 0; rdy = 1;
        for (int i = 0; i < 5; i++) begin
            #1 chk($sformatf("err%0d_ctl", i), 32'(ctl), 32'b00000);
            chk($sformatf("err%0d_flag", i), 32'(mem_err), 1);
            tick();
        end
        chk("err_stall_max", 32'(stall_cnt), 15);
        for (int i = 0; i < 5; i++) tick();
        chk("stall_saturated", 32'(stall_cnt), 15);
        chk("err_flush", 32'(flush_cnt), 1);
        clr();
        reset = 1;
        #1 chk("rst_err_ctl", 32'(ctl), 32'b00110);
        chk("rst_err_stall", 32'(stall_cnt), 0);
        chk("rst_err_flush", 32'(flush_cnt), 0);
        chk("rst_err_flag", 32'(mem_err), 0);
        tick();
        reset = 0; req = 1; rdy = 0;
        #1 chk("w6_enter_ctl", 32'(ctl), 32'b00000);
        tick();
        tick();
        reset = 1;
        #1 chk("rst_wait_ctl", 32'(ctl), 32'b00110);
        chk("rst_wait_stall", 32'(stall_cnt), 0);
        tick();
        clr();
        reset = 0;
        #1 chk("post_rst_ctl", 32'(ctl), 32'b11001);
        chk("post_rst_err", 32'(mem_err), 0);
        tick();
        chk("post_rst_stall", 32'(stall_cnt), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
